// File: rtl/axi_sram_rsp.sv
// axi_sram_rsp: AXI4-Lite responder in front of a word-addressed SRAM.
// Single-beat 32-bit reads and writes. The read and write paths are independent
// state machines (IDLE/WAIT/DONE), each with its own access-delay counter.
// Addresses outside [BASE, BASE+4*DEPTH) answer SLVERR and never touch memory.
// Optional feature: define AXI_SRAM_RSP_RAND_DELAY_EN to add 0..3 extra wait
// cycles per access, drawn from an 8-bit LFSR.
module axi_sram_rsp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [31:0] ar_addr,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] aw_addr,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [1:0]  b_resp
);

  localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] BASE_X = {1'b0, BASE};
  localparam logic [32:0] SPAN   = 33'(4 * DEPTH);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      rstate, rstate_nx;
  state_t      wstate, wstate_nx;
  logic [3:0]  rcnt, wcnt;
  logic [3:0]  load_val;
  logic [31:0] mem [DEPTH];

  logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_got, w_got;

  logic        ar_hs, aw_hs, w_hs, w_start;
  logic        rd_cap, wr_commit;
  logic [31:0] rd_addr_eff, wr_addr_eff, wr_data_eff;
  logic [3:0]  wr_strb_eff;
  logic [32:0] rd_off, wr_off;
  logic        rd_in, wr_in;
  logic [IDX_W-1:0] rd_idx, wr_idx;

`ifdef AXI_SRAM_RSP_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Delay load saturates so the 4-bit counter never wraps.
  function automatic logic [3:0] sat_load(input logic [1:0] extra);
    logic [4:0] sum;
    sum = 5'(LATENCY) + {3'b000, extra};
    return (sum > 5'd15) ? 4'hF : sum[3:0];
  endfunction

  // Free-running LFSR, taps for x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign load_val = sat_load(lfsr[1:0]);
`else
  assign load_val = 4'(LATENCY);
`endif

  // Handshakes, effective addresses/data and range decode.
  always_comb begin
    ar_hs       = ar_valid && ar_ready;
    aw_hs       = aw_valid && aw_ready;
    w_hs        = w_valid && w_ready;
    w_start     = (wstate == S_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
    rd_addr_eff = (rstate == S_IDLE) ? ar_addr : ar_addr_q;
    wr_addr_eff = (wstate == S_IDLE && !aw_got) ? aw_addr : aw_addr_q;
    wr_data_eff = (wstate == S_IDLE && !w_got) ? w_data : w_data_q;
    wr_strb_eff = (wstate == S_IDLE && !w_got) ? w_strb : w_strb_q;
    rd_off      = {1'b0, rd_addr_eff} - BASE_X;
    wr_off      = {1'b0, wr_addr_eff} - BASE_X;
    rd_in       = !rd_off[32] && (rd_off < SPAN);
    wr_in       = !wr_off[32] && (wr_off < SPAN);
    rd_idx      = rd_off[IDX_W+1:2];
    wr_idx      = wr_off[IDX_W+1:2];
    // Capture/commit happens on the edge the counter would reach zero,
    // so the response becomes visible LATENCY+1 cycles after acceptance.
    rd_cap      = (ar_hs && load_val == 4'd0) || (rstate == S_WAIT && rcnt <= 4'd1);
    wr_commit   = (w_start && load_val == 4'd0) || (wstate == S_WAIT && wcnt <= 4'd1);
  end

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) rstate <= S_IDLE;
    else       rstate <= rstate_nx;
  end

  // Read FSM next state.
  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      S_IDLE: if (ar_hs) rstate_nx = (load_val == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT: if (rcnt <= 4'd1) rstate_nx = S_DONE;
      S_DONE: if (r_ready) rstate_nx = S_IDLE;
      default: rstate_nx = S_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    ar_ready = (rstate == S_IDLE) && !rst_i;
    r_valid  = (rstate == S_DONE);
  end

  // Read counter and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt   <= 4'd0;
      r_data <= 32'h0;
      r_resp <= OKAY;
    end else begin
      if (ar_hs)                             rcnt <= load_val;
      else if (rstate == S_WAIT && rcnt != 0) rcnt <= rcnt - 4'd1;
      if (rd_cap) begin
        r_data <= rd_in ? mem[rd_idx] : 32'h0;
        r_resp <= rd_in ? OKAY : SLVERR;
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) wstate <= S_IDLE;
    else       wstate <= wstate_nx;
  end

  // Write FSM next state.
  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      S_IDLE: if (w_start) wstate_nx = (load_val == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT: if (wcnt <= 4'd1) wstate_nx = S_DONE;
      S_DONE: if (b_ready) wstate_nx = S_IDLE;
      default: wstate_nx = S_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    aw_ready = (wstate == S_IDLE) && !aw_got && !rst_i;
    w_ready  = (wstate == S_IDLE) && !w_got && !rst_i;
    b_valid  = (wstate == S_DONE);
  end

  // Write-side control: AW/W latched flags, counter, response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      wcnt   <= 4'd0;
      b_resp <= OKAY;
    end else begin
      if (w_start) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (w_start)                            wcnt <= load_val;
      else if (wstate == S_WAIT && wcnt != 0) wcnt <= wcnt - 4'd1;
      if (wr_commit) b_resp <= wr_in ? OKAY : SLVERR;
    end
  end

  // Request holding registers; data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (ar_hs) ar_addr_q <= ar_addr;
    if (aw_hs) aw_addr_q <= aw_addr;
    if (w_hs) begin
      w_data_q <= w_data;
      w_strb_q <= w_strb;
    end
  end

  // Byte-enabled memory commit; a reset on the commit edge drops the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_commit && wr_in) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_eff[i]) mem[wr_idx][8*i +: 8] <= wr_data_eff[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_rsp.sv
// Directed bench for axi_sram_rsp (BASE 32'h8000_0000, DEPTH 1024, LATENCY 3).
// Honours AXI_SRAM_RSP_RAND_DELAY_EN when checking response latency.
module tb_axi_sram_rsp;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ar_valid = 1'b0, ar_ready;
  logic [31:0] ar_addr = 32'h0;
  logic        r_valid, r_ready = 1'b0;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] aw_addr = 32'h0;
  logic        w_valid = 1'b0, w_ready;
  logic [31:0] w_data = 32'h0;
  logic [3:0]  w_strb = 4'h0;
  logic        b_valid, b_ready = 1'b0;
  logic [1:0]  b_resp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_sram_rsp #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int lat);
    bit ok;
`ifdef AXI_SRAM_RSP_RAND_DELAY_EN
    ok = (lat >= LAT + 1) && (lat <= LAT + 4);
`else
    ok = (lat == LAT + 1);
`endif
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got latency %0d expected %0d..%0d", name, lat, LAT + 1, LAT + 4);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    ar_valid = 1'b1;
    ar_addr  = a;
    n = 0;
    while (!ar_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ar_ready_wait", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
    lat = 1;
    while (!r_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk_lat("rd_latency", lat);
    d    = r_data;
    resp = r_resp;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("r_valid_drop", r_valid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int b_hold,
                          output logic [1:0] resp, output int lat);
    bit awp, wp, awa, wa;
    int cyc;
    awp = 1'b1;
    wp  = 1'b1;
    cyc = 0;
    while ((awp || wp) && cyc < 50) begin
      w_valid  = wp;
      w_data   = d;
      w_strb   = s;
      aw_valid = awp && (cyc >= w_lead);
      aw_addr  = a;
      if (!wp && awp) chk("w_ready_low_after_w", w_ready, 0);
      awa = aw_valid && aw_ready;
      wa  = w_valid && w_ready;
      tick();
      cyc++;
      if (awa) awp = 1'b0;
      if (wa)  wp  = 1'b0;
    end
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    chk("aw_w_accepted", {30'h0, awp, wp}, 0);
    lat = 1;
    while (!b_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk_lat("wr_latency", lat);
    resp = b_resp;
    for (int i = 0; i < b_hold; i++) begin
      tick();
      chk("b_valid_hold", b_valid, 1);
      chk("b_resp_hold", b_resp, resp);
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("b_valid_drop", b_valid, 0);
  endtask

  initial begin
    vec_t        vecs[14];
    logic [31:0] d;
    logic [1:0]  resp;
    int          lat;
    int          n;
    bit          saw_b;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0,         2'b00};
    vecs[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 2'b00};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0,         4'hF, 32'h0,         2'b00};
    vecs[6]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 32'h0,         2'b00};
    vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[8]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
    vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hFF00_0000, 2'b00};
    vecs[10] = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
    vecs[11] = '{1'b0, 32'h8000_0FFF, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};
    vecs[12] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[13] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};

    // Reset state while rst_i is held high.
    tick();
    tick();
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_b_resp", b_resp, 0);
    rst_i = 1'b0;
    tick();
    chk("idle_ar_ready", ar_ready, 1);
    chk("idle_aw_ready", aw_ready, 1);
    chk("idle_w_ready", w_ready, 1);

    // Table-driven single transactions.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, resp, lat);
        chk($sformatf("vec%0d_b_resp", i), resp, vecs[i].exp_resp);
      end else begin
        do_read(vecs[i].addr, d, resp, lat);
        chk($sformatf("vec%0d_r_data", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_r_resp", i), resp, vecs[i].exp_resp);
      end
    end

    // W two cycles ahead of AW, response held off for five cycles.
    do_write(32'h8000_0024, 32'h0F0F_0F0F, 4'hF, 2, 5, resp, lat);
    chk("wfirst_b_resp", resp, 2'b00);
    do_read(32'h8000_0024, d, resp, lat);
    chk("wfirst_r_data", d, 32'h0F0F_0F0F);

    // Read and write to the same word accepted together: read sees old data.
    do_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 0, resp, lat);
    ar_valid = 1'b1; ar_addr = 32'h8000_0040;
    aw_valid = 1'b1; aw_addr = 32'h8000_0040;
    w_valid  = 1'b1; w_data  = 32'h600D_CAFE; w_strb = 4'hF;
    chk("coll_ar_ready", ar_ready, 1);
    chk("coll_aw_ready", aw_ready, 1);
    tick();
    ar_valid = 1'b0; aw_valid = 1'b0; w_valid = 1'b0;
    n = 1;
    while (!r_valid && n < 50) begin
      tick();
      n++;
    end
    chk_lat("coll_rd_latency", n);
    chk("coll_b_valid_same_cycle", b_valid, 1);
    chk("coll_r_data_old", r_data, 32'h0BAD_F00D);
    r_ready = 1'b1; b_ready = 1'b1;
    tick();
    r_ready = 1'b0; b_ready = 1'b0;
    do_read(32'h8000_0040, d, resp, lat);
    chk("coll_after_write", d, 32'h600D_CAFE);

    // Reset during write WAIT drops the write.
    do_write(32'h8000_0030, 32'h55AA_55AA, 4'hF, 0, 0, resp, lat);
    do_read(32'h8000_0030, d, resp, lat);
    chk("pre_rst_r_data", d, 32'h55AA_55AA);
    aw_valid = 1'b1; aw_addr = 32'h8000_0030;
    w_valid  = 1'b1; w_data  = 32'hFFFF_FFFF; w_strb = 4'hF;
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    chk("midrst_ar_ready", ar_ready, 0);
    chk("midrst_aw_ready", aw_ready, 0);
    chk("midrst_w_ready", w_ready, 0);
    tick();
    chk("midrst_b_valid", b_valid, 0);
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_r_data", r_data, 0);
    chk("midrst_b_resp", b_resp, 0);
    rst_i = 1'b0;
    saw_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b_valid) saw_b = 1'b1;
    end
    chk("midrst_no_b_valid", {31'h0, saw_b}, 0);
    do_read(32'h8000_0030, d, resp, lat);
    chk("midrst_word_kept", d, 32'h55AA_55AA);

    // Repeated reads: latency bounds and data.
    for (int i = 0; i < 100; i++) begin
      do_read(32'h8000_0010, d, resp, lat);
      if (d !== 32'hDEAD_BEEF || resp !== 2'b00) chk($sformatf("rep%0d_data", i), d, 32'hDEAD_BEEF);
    end
    do_read(32'h8000_0010, d, resp, lat);
    chk("rep_final_data", d, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
